// File: rtl/mips_defs.sv
// Shared MIPS pipeline definitions: exception codes, reset/handler vectors,
// legal instruction-memory window and the bubble instruction word.
package mips_defs;
  localparam logic [4:0]  EXC_NONE       = 5'd0;
  localparam logic [4:0]  EXC_ADEL       = 5'd4;
  localparam logic [31:0] RESET_PC_DEF   = 32'h0000_3000;
  localparam logic [31:0] EXC_ENTRY_DEF  = 32'h0000_4180;
  localparam logic [31:0] IM_LO_DEF      = 32'h0000_3000;
  localparam logic [31:0] IM_HI_DEF      = 32'h0000_6ffc;
  localparam logic [31:0] NOP            = 32'h0000_0000;
endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// F/D pipeline latch.
//   load_en    : capture this cycle (low = hold)
//   bubble     : when loading, insert a NOP bubble whose PCn is bubble_pcn
//   op/pcn/delay/exc_i : normal fetch payload
//   *_o        : registered values to decode
// Synchronous active-high reset.
module if_id_reg
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load_en,
  input  logic        bubble,
  input  logic [31:0] bubble_pcn,
  input  logic [31:0] op_i,
  input  logic [31:0] pcn_i,
  input  logic        delay_i,
  input  logic [4:0]  exc_i,
  output logic [31:0] op_o,
  output logic [31:0] pcn_o,
  output logic        delay_o,
  output logic [4:0]  exc_o
);
  logic [31:0] op_q, op_d, pcn_q, pcn_d;
  logic        delay_q, delay_d;
  logic [4:0]  exc_q, exc_d;

  always_comb begin
    op_d    = op_q;
    pcn_d   = pcn_q;
    delay_d = delay_q;
    exc_d   = exc_q;
    if (load_en) begin
      if (bubble) begin
        op_d    = NOP;
        pcn_d   = bubble_pcn;
        delay_d = 1'b0;
        exc_d   = EXC_NONE;
      end else begin
        op_d    = op_i;
        pcn_d   = pcn_i;
        delay_d = delay_i;
        exc_d   = exc_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= NOP;
      pcn_q   <= RESET_PC + 32'd4;
      delay_q <= 1'b0;
      exc_q   <= EXC_NONE;
    end else begin
      op_q    <= op_d;
      pcn_q   <= pcn_d;
      delay_q <= delay_d;
      exc_q   <= exc_d;
    end
  end

  assign op_o    = op_q;
  assign pcn_o   = pcn_q;
  assign delay_o = delay_q;
  assign exc_o   = exc_q;
endmodule

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns PC_F, drives instruction memory
// (zero-latency, combinational), and registers the F/D latch.
// Ports: clk/reset (sync, active-high); i_inst_addr/i_inst_rdata to IM;
// stall, req (CP0), br_take_D/br_target_D, eret_D/epc, is_jb_D redirects;
// OP_D_o, PCn_D_o, Delay_D_o, ExcCode_D_o to decode.
// Config macro FETCH_ADEL_EN: enables fetch address-error (AdEL) detection.
// Without it, every fetch is passed through with ExcCode 0.
module fetch_stage
  import mips_defs::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] EXC_ENTRY = EXC_ENTRY_DEF,
  parameter logic [31:0] IM_LO     = IM_LO_DEF,
  parameter logic [31:0] IM_HI     = IM_HI_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  input  logic        stall,
  input  logic        req,
  input  logic        br_take_D,
  input  logic [31:0] br_target_D,
  input  logic        eret_D,
  input  logic [31:0] epc,
  input  logic        is_jb_D,
  output logic [31:0] OP_D_o,
  output logic [31:0] PCn_D_o,
  output logic        Delay_D_o,
  output logic [4:0]  ExcCode_D_o
);
  logic [31:0] pc_q, pc_d, pc_plus4, op_f, bub_pcn;
  logic        adel, load_en, bubble;
  logic [4:0]  exc_f;

  assign pc_plus4    = pc_q + 32'd4;  // wraps modulo 2^32
  assign i_inst_addr = pc_q;

`ifdef FETCH_ADEL_EN
  assign adel = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
`else
  assign adel = 1'b0;
`endif

  assign op_f  = adel ? NOP : i_inst_rdata;
  assign exc_f = adel ? EXC_ADEL : EXC_NONE;

  // Redirect priority: req > stall > eret > branch > sequential.
  // Misaligned targets are loaded as-is; the error surfaces on fetch.
  always_comb begin
    pc_d = pc_plus4;
    if (req)            pc_d = EXC_ENTRY;
    else if (stall)     pc_d = pc_q;
    else if (eret_D)    pc_d = epc;
    else if (br_take_D) pc_d = br_target_D;
  end

  // req and eret discard the word in F; a bubble still carries a valid
  // PCn so an interrupt landing on it can recover the macroscopic PC.
  assign load_en = req | ~stall;
  assign bubble  = req | eret_D;
  assign bub_pcn = req ? (EXC_ENTRY + 32'd4) : (epc + 32'd4);

  always_ff @(posedge clk) begin
    if (reset) pc_q <= RESET_PC;
    else       pc_q <= pc_d;
  end

  if_id_reg #(.RESET_PC(RESET_PC)) u_if_id (
    .clk        (clk),
    .reset      (reset),
    .load_en    (load_en),
    .bubble     (bubble),
    .bubble_pcn (bub_pcn),
    .op_i       (op_f),
    .pcn_i      (pc_plus4),
    .delay_i    (is_jb_D),
    .exc_i      (exc_f),
    .op_o       (OP_D_o),
    .pcn_o      (PCn_D_o),
    .delay_o    (Delay_D_o),
    .exc_o      (ExcCode_D_o)
  );
endmodule
